// File: rtl/sseg_num_writer.sv
// sseg_num_writer: converts a signed two's-complement value to BCD and writes it
// digit by digit (least significant first) into a seven-segment display array.
// Ports:
//   clk, reset (async, active-low)
//   start, value        - conversion request and signed number to show
//   dp_en, dp_pos       - decimal point enable and digit position
//   lz_blank, blink_in  - leading-zero blanking, blink-all request
//   busy, done, ovf     - conversion active, completion pulse, overflow flag
//   wr, sel, val        - write strobe, digit index, BCD digit
//   sseg_en, sign, dp, blink - per-digit attributes, valid while wr=1
module sseg_num_writer #(
    parameter int unsigned SSEG_BITS = 2,
    parameter int unsigned SSEG_N    = 3,
    parameter int unsigned VAL_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [VAL_BITS-1:0]  value,
    input  logic                 dp_en,
    input  logic [SSEG_BITS-1:0] dp_pos,
    input  logic                 lz_blank,
    input  logic                 blink_in,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 wr,
    output logic [SSEG_BITS-1:0] sel,
    output logic [3:0]           val,
    output logic                 sseg_en,
    output logic                 sign,
    output logic                 dp,
    output logic                 blink
);

    localparam int unsigned BCD_W   = 4 * SSEG_N;
    localparam int unsigned CNT_W   = $clog2(VAL_BITS + 1);
    localparam int unsigned POS_MAX = 10**SSEG_N - 1;
    localparam int unsigned NEG_MAX = 10**(SSEG_N - 1) - 1;
    localparam int          TOP_POS = int'(SSEG_N) - 1;
    localparam int          TOP_NEG = int'(SSEG_N) - 2;

    typedef enum logic [2:0] {S_IDLE, S_ABS, S_CONV, S_WRITE, S_DONE} state_t;

    state_t state, state_nxt;

    logic [VAL_BITS-1:0]  val_l;
    logic                 dp_en_l, lz_l, blink_l, neg_l;
    logic [SSEG_BITS-1:0] dp_pos_l;
    logic [VAL_BITS-1:0]  mag_sh;
    logic [BCD_W-1:0]     bcd;
    logic [CNT_W-1:0]     cnt;

    logic [VAL_BITS-1:0]  mag_c;
    logic [BCD_W-1:0]     bcd_adj, bcd_step, bcd_src;
    logic [SSEG_BITS-1:0] idx_nxt;
    logic [3:0]           d_val, d_digit;
    logic                 d_en, d_sign, d_dp, d_blink;
    logic                 zero_run, upper_zero;
    int                   top;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ABS;
            S_ABS:   state_nxt = S_CONV;
            S_CONV:  if (cnt == CNT_W'(VAL_BITS - 1)) state_nxt = S_WRITE;
            S_WRITE: if (sel == SSEG_BITS'(SSEG_N - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Magnitude of the latched value; the most-negative value maps to 2**(VAL_BITS-1)
    always_comb begin
        mag_c = val_l[VAL_BITS-1] ? (~val_l + VAL_BITS'(1)) : val_l;
    end

    // One shift-add-3 step: correct digits >= 5, then shift in the next magnitude bit
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(SSEG_N); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_step = (bcd_adj << 1) | BCD_W'(mag_sh[VAL_BITS-1]);
    end

    // Attributes of the digit written on the next cycle. The final conversion step
    // and the first write share an edge, so digit 0 is taken from bcd_step.
    always_comb begin
        idx_nxt    = (state == S_WRITE) ? sel + SSEG_BITS'(1) : '0;
        bcd_src    = (state == S_CONV) ? bcd_step : bcd;
        top        = neg_l ? TOP_NEG : TOP_POS;
        zero_run   = 1'b1;
        upper_zero = 1'b0;
        d_digit    = 4'd0;
        for (int i = int'(SSEG_N) - 1; i >= 0; i--) begin
            if (i <= top && bcd_src[4*i +: 4] != 4'd0) zero_run = 1'b0;
            if (i == int'(idx_nxt)) begin
                upper_zero = zero_run;
                d_digit    = bcd_src[4*i +: 4];
            end
        end

        d_dp    = dp_en_l && (idx_nxt == dp_pos_l);
        d_val   = d_digit;
        d_sign  = 1'b0;
        d_en    = 1'b1;
        d_blink = blink_l;
        if (neg_l && int'(idx_nxt) == TOP_POS) begin
            d_val  = 4'd0;
            d_sign = 1'b1;
        end else if (ovf) begin
            d_val   = 4'd9;
            d_blink = 1'b1;
        end else if (lz_l && idx_nxt != '0 && upper_zero &&
                     !(dp_en_l && idx_nxt <= dp_pos_l)) begin
            d_en = 1'b0;
        end
    end

    // Operand latch, magnitude and BCD conversion datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val_l    <= '0;
            dp_en_l  <= 1'b0;
            dp_pos_l <= '0;
            lz_l     <= 1'b0;
            blink_l  <= 1'b0;
            neg_l    <= 1'b0;
            mag_sh   <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    val_l    <= value;
                    dp_en_l  <= dp_en;
                    dp_pos_l <= dp_pos;
                    lz_l     <= lz_blank;
                    blink_l  <= blink_in;
                    ovf      <= 1'b0;
                end
                S_ABS: begin
                    neg_l  <= val_l[VAL_BITS-1];
                    mag_sh <= mag_c;
                    bcd    <= '0;
                    cnt    <= '0;
                    ovf    <= val_l[VAL_BITS-1] ? (32'(mag_c) > NEG_MAX)
                                                : (32'(mag_c) > POS_MAX);
                end
                S_CONV: begin
                    mag_sh <= mag_sh << 1;
                    bcd    <= bcd_step;
                    cnt    <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered status and display-write outputs, driven from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wr      <= 1'b0;
            sel     <= '0;
            val     <= 4'd0;
            sseg_en <= 1'b0;
            sign    <= 1'b0;
            dp      <= 1'b0;
            blink   <= 1'b0;
        end else begin
            busy <= (state_nxt == S_ABS) || (state_nxt == S_CONV) || (state_nxt == S_WRITE);
            done <= (state_nxt == S_DONE);
            wr   <= (state_nxt == S_WRITE);
            if (state_nxt == S_WRITE) begin
                sel     <= idx_nxt;
                val     <= d_val;
                sseg_en <= d_en;
                sign    <= d_sign;
                dp      <= d_dp;
                blink   <= d_blink;
            end else begin
                sel     <= '0;
                val     <= 4'd0;
                sseg_en <= 1'b0;
                sign    <= 1'b0;
                dp      <= 1'b0;
                blink   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_num_writer.sv
// Self-checking bench for sseg_num_writer: an arithmetic reference model tracks
// each accepted conversion and a compare process checks every cycle, while
// directed tests pin individual digit writes to hand-computed values.
module tb_sseg_num_writer;

    localparam int SB = 2;
    localparam int N  = 3;
    localparam int V  = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [V-1:0]  value = '0;
    logic          dp_en = 1'b0;
    logic [SB-1:0] dp_pos = '0;
    logic          lz_blank = 1'b0;
    logic          blink_in = 1'b0;
    logic          busy, done, ovf, wr, sseg_en, sign, dp, blink;
    logic [SB-1:0] sel;
    logic [3:0]    val;

    sseg_num_writer #(.SSEG_BITS(SB), .SSEG_N(N), .VAL_BITS(V)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .dp_en(dp_en), .dp_pos(dp_pos), .lz_blank(lz_blank), .blink_in(blink_in),
        .busy(busy), .done(done), .ovf(ovf), .wr(wr), .sel(sel), .val(val),
        .sseg_en(sseg_en), .sign(sign), .dp(dp), .blink(blink)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int p10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    // Packed write record {sel, val, sseg_en, sign, dp, blink}
    function automatic logic [9:0] rec(input int s, input int v, input bit en,
                                       input bit sg, input bit d, input bit b);
        return {2'(s), 4'(v), en, sg, d, b};
    endfunction

    // ---------------- reference model ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit m_act = 1'b0;
    int j = 0;
    int m_mag = 0, m_dpp = 0, start_cyc = -1;
    bit m_neg = 1'b0, m_ovf = 1'b0, m_lz = 1'b0, m_dpen = 1'b0, m_bl = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        int v;
        if (!reset) begin
            m_act <= 1'b0;
            m_ovf <= 1'b0;
        end else if (m_act) begin
            if (j == V + N + 1) m_act <= 1'b0;
            else                j <= j + 1;
        end else if (start) begin
            v = int'($signed(value));
            m_act     <= 1'b1;
            j         <= 0;
            m_neg     <= (v < 0);
            m_mag     <= (v < 0) ? -v : v;
            m_ovf     <= (v < 0) ? (-v > p10(N - 1) - 1) : (v > p10(N) - 1);
            m_lz      <= lz_blank;
            m_dpen    <= dp_en;
            m_dpp     <= int'(dp_pos);
            m_bl      <= blink_in;
            start_cyc <= cyc;
        end
    end

    function automatic logic [9:0] exp_rec(input int d);
        int  v4 = 0;
        bit  en = 1'b1, sg = 1'b0, bl = m_bl;
        bit  dpb = m_dpen && (d == m_dpp);
        if (m_neg && d == N - 1) begin
            sg = 1'b1;
        end else if (m_ovf) begin
            v4 = 9;
            bl = 1'b1;
        end else begin
            v4 = (m_mag / p10(d)) % 10;
            if (m_lz && d > 0 && m_mag < p10(d) && !(m_dpen && d <= m_dpp)) en = 1'b0;
        end
        return rec(d, v4, en, sg, dpb, bl);
    endfunction

    // ---------------- compare process ----------------
    logic [9:0] wlog[$];
    int done_cyc = -1;
    int busy_rise = -100, busy_rise_prev = -100;
    bit busy_q = 1'b0;
    wire [9:0] rec_out = {sel, val, sseg_en, sign, dp, blink};

    always @(negedge clk) begin : compare
        bit eb, ed, ew;
        if (!reset) begin
            check("reset_outputs", 32'({busy, done, ovf, wr, sel, val, sseg_en, sign, dp, blink}), 32'd0);
        end else begin
            eb = m_act && j <= V + N;
            ed = m_act && j == V + N + 1;
            ew = m_act && j >= V + 1 && j <= V + N;
            check("busy_done_wr", 32'({busy, done, wr}), 32'({eb, ed, ew}));
            if (ew) check("digit_write", 32'(rec_out), 32'(exp_rec(j - V - 1)));
            if (!(m_act && j == 0)) check("ovf", 32'(ovf), 32'(m_ovf));
            if (wr) wlog.push_back(rec_out);
            if (done) done_cyc = cyc;
            if (busy && !busy_q) begin
                busy_rise_prev = busy_rise;
                busy_rise      = cyc;
            end
        end
        busy_q = busy;
    end

    // ---------------- stimulus ----------------
    task automatic kick(input int v, input bit lz, input bit dpe, input int dpp, input bit bl);
        @(negedge clk);
        value    = V'(v);
        lz_blank = lz;
        dp_en    = dpe;
        dp_pos   = SB'(dpp);
        blink_in = bl;
        start    = 1'b1;
        wlog.delete();
        done_cyc = -1;
        @(negedge clk);
        start    = 1'b0;
        // Scramble inputs mid-conversion; the latched copies must be used
        value    = ~value;
        lz_blank = ~lz;
        dp_en    = ~dpe;
        blink_in = ~bl;
    endtask

    task automatic conv(input int v, input bit lz, input bit dpe, input int dpp, input bit bl);
        kick(v, lz, dpe, dpp, bl);
        repeat (V + N + 4) @(negedge clk);
    endtask

    task automatic chk_log(input string name, input logic [9:0] r0,
                           input logic [9:0] r1, input logic [9:0] r2);
        logic [9:0] r[3];
        r[0] = r0; r[1] = r1; r[2] = r2;
        check({name, "_count"}, 32'(wlog.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < wlog.size()) check({name, "_w", $sformatf("%0d", i)}, 32'(wlog[i]), 32'(r[i]));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        conv(123, 0, 0, 0, 0);
        chk_log("v123", rec(0,3,1,0,0,0), rec(1,2,1,0,0,0), rec(2,1,1,0,0,0));
        check("v123_done_cycle", 32'(done_cyc - start_cyc), 32'd15);
        check("v123_ovf", 32'(ovf), 32'd0);

        conv(7, 1, 0, 0, 0);
        chk_log("v7_lz", rec(0,7,1,0,0,0), rec(1,0,0,0,0,0), rec(2,0,0,0,0,0));

        conv(-45, 0, 0, 0, 0);
        chk_log("vm45", rec(0,5,1,0,0,0), rec(1,4,1,0,0,0), rec(2,0,1,1,0,0));
        check("vm45_ovf", 32'(ovf), 32'd0);

        conv(-100, 0, 0, 0, 1);
        chk_log("vm100", rec(0,9,1,0,0,1), rec(1,9,1,0,0,1), rec(2,0,1,1,0,1));
        check("vm100_ovf", 32'(ovf), 32'd1);

        conv(-512, 0, 0, 0, 1);
        chk_log("vm512", rec(0,9,1,0,0,1), rec(1,9,1,0,0,1), rec(2,0,1,1,0,1));
        check("vm512_ovf", 32'(ovf), 32'd1);

        conv(0, 1, 1, 1, 0);
        chk_log("v0_dp1", rec(0,0,1,0,0,0), rec(1,0,1,0,1,0), rec(2,0,0,0,0,0));

        conv(-99, 1, 1, 2, 0);
        chk_log("vm99", rec(0,9,1,0,0,0), rec(1,9,1,0,0,0), rec(2,0,1,1,1,0));
        check("vm99_ovf", 32'(ovf), 32'd0);

        conv(511, 1, 0, 0, 1);
        chk_log("v511", rec(0,1,1,0,0,1), rec(1,1,1,0,0,1), rec(2,5,1,0,0,1));

        // Start re-pulsed at k+5 while busy must be ignored
        kick(321, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        value = V'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (V + N + 2) @(negedge clk);
        chk_log("busy_start", rec(0,1,1,0,0,0), rec(1,2,1,0,0,0), rec(2,3,1,0,0,0));

        // Reset during the second write: no further writes and no done
        kick(123, 0, 0, 0, 0);
        repeat (12) @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_writes", 32'(wlog.size()), 32'd1);
        check("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        conv(-45, 0, 0, 0, 0);
        chk_log("after_reset", rec(0,5,1,0,0,0), rec(1,4,1,0,0,0), rec(2,0,1,1,0,0));

        // Start held high: ignored during DONE, accepted in the following IDLE cycle
        @(negedge clk);
        value = V'(42);
        start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (V + N + 4) @(negedge clk);
        check("restart_gap", 32'(busy_rise - busy_rise_prev), 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
